seq_cskb_sub: RTL and testbench



---
 rtl/seq_cskb_sub.sv | 149 ++++++++++++++
 tb/tb_seq_cskb_sub.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_cskb_sub.sv
// seq_cskb_sub: sequential carry-skip subtractor, one BLOCK-bit group per clock.
// Computes a - b as a + ~b + 1. Each group's outgoing carry is selected
// between its ripple carry and a bypass of its incoming carry. The bypass is
// taken when every bit in the group propagates. The result is handed off
// through a valid/ready pair.
module seq_cskb_sub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH:0]                diff_out,
    output logic                          borrow,
    output logic [$clog2(WIDTH/BLOCK):0]  skip_cnt
);

    localparam int NBLK   = WIDTH / BLOCK;
    localparam int IDX_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int SKIP_W = $clog2(NBLK) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   nb_q;
    logic               carry_q;
    logic [IDX_W-1:0]   blk_q;

    logic [BLOCK-1:0]   a_slice;
    logic [BLOCK-1:0]   nb_slice;
    logic [BLOCK-1:0]   sum_slice;
    logic               blk_prop;
    logic               ripple_carry;
    logic               carry_next;
    logic               last_blk;
    logic               accept;
    logic               handoff;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign handoff   = out_valid & out_ready;
    assign last_blk  = (blk_q == IDX_W'(NBLK - 1));

    assign a_slice   = a_q[blk_q*BLOCK +: BLOCK];
    assign nb_slice  = nb_q[blk_q*BLOCK +: BLOCK];

    // Ripple through the current group; skip mux picks the bypass when the whole group propagates
    always_comb begin
        logic c;
        sum_slice = '0;
        c         = carry_q;
        for (int i = 0; i < BLOCK; i++) begin
            sum_slice[i] = a_slice[i] ^ nb_slice[i] ^ c;
            c            = (a_slice[i] & nb_slice[i]) | (c & (a_slice[i] ^ nb_slice[i]));
        end
        ripple_carry = c;
        blk_prop     = &(a_slice ^ nb_slice);
        carry_next   = blk_prop ? carry_q : ripple_carry;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, walk every group in CALC, hold in DONE until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_blk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (handoff) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then commit one group of sum bits per CALC edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            nb_q     <= '0;
            carry_q  <= 1'b0;
            blk_q    <= '0;
            diff_out <= '0;
            borrow   <= 1'b0;
            skip_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= a;
                        nb_q     <= ~b;
                        carry_q  <= 1'b1;
                        blk_q    <= '0;
                        diff_out <= '0;
                        borrow   <= 1'b0;
                        skip_cnt <= '0;
                    end
                end
                CALC: begin
                    diff_out[blk_q*BLOCK +: BLOCK] <= sum_slice;
                    carry_q                        <= carry_next;
                    blk_q                          <= blk_q + IDX_W'(1);
                    if (blk_prop) begin
                        skip_cnt <= skip_cnt + SKIP_W'(1);
                    end
                    if (last_blk) begin
                        diff_out[WIDTH] <= carry_next;
                        borrow          <= ~carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cskb_sub.sv
// tb_seq_cskb_sub: directed and randomized self-checking bench for seq_cskb_sub.
// Expected results come from plain arithmetic on the operands (a - b, a >= b,
// count of equal operand groups).
module tb_seq_cskb_sub;

    localparam int WIDTH  = 16;
    localparam int BLOCK  = 4;
    localparam int NBLK   = WIDTH / BLOCK;
    localparam int SKIP_W = $clog2(NBLK) + 1;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH:0]      diff_out;
    logic                borrow;
    logic [SKIP_W-1:0]   skip_cnt;

    int checks;
    int failures;

    logic [WIDTH:0]      last_diff;
    logic                last_borrow;
    logic [SKIP_W-1:0]   last_skip;

    seq_cskb_sub #(
        .WIDTH(WIDTH),
        .BLOCK(BLOCK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff_out (diff_out),
        .borrow   (borrow),
        .skip_cnt (skip_cnt)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck design cannot hang the run
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH:0] refDiff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x - y;
        return {(x >= y), d};
    endfunction

    function automatic int refSkip(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n;
        n = 0;
        for (int k = 0; k < NBLK; k++) begin
            if (x[k*BLOCK +: BLOCK] == y[k*BLOCK +: BLOCK]) n++;
        end
        return n;
    endfunction

    // Run one operation starting at a negedge; stall the consumer for 'stall' cycles
    task automatic applyStimulus(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                                 input int stall);
        int cyc;
        logic [WIDTH:0] exp_diff;
        logic [SKIP_W-1:0] exp_skip;
        exp_diff = refDiff(opa, opb);
        exp_skip = SKIP_W'(refSkip(opa, opb));

        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);

        a         = opa;
        b         = opb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;

        cyc = 0;
        while (!out_valid && cyc < 50) begin
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'(NBLK));
        checkOutput("in_ready_done", 32'(in_ready), 32'd0);
        checkOutput("diff", 32'(diff_out), 32'(exp_diff));
        checkOutput("borrow", 32'(borrow), 32'(opa < opb));
        checkOutput("skip_cnt", 32'(skip_cnt), 32'(exp_skip));
        last_diff   = diff_out;
        last_borrow = borrow;
        last_skip   = skip_cnt;

        for (int s = 0; s < stall; s++) begin
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_result", 32'({diff_out, borrow, skip_cnt}),
                        32'({exp_diff, (opa < opb), exp_skip}));
        end

        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("post_handoff_valid", 32'(out_valid), 32'd0);
        checkOutput("post_handoff_ready", 32'(in_ready), 32'd1);
    endtask

    // Main sequence: reset, directed vectors, back-pressure, mid-op reset, random soak
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_diff", 32'(diff_out), 32'd0);
        checkOutput("reset_borrow", 32'(borrow), 32'd0);
        checkOutput("reset_skip", 32'(skip_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h0234, 0);
        checkOutput("vec1_diff", 32'(last_diff), 32'h11000);
        checkOutput("vec1_skip", 32'(last_skip), 32'd3);

        applyStimulus(16'h0000, 16'h0001, 0);
        checkOutput("vec2_diff", 32'(last_diff), 32'h0FFFF);
        checkOutput("vec2_borrow", 32'(last_borrow), 32'd1);
        checkOutput("vec2_skip", 32'(last_skip), 32'd3);

        applyStimulus(16'hBEEF, 16'hBEEF, 0);
        checkOutput("vec3_diff", 32'(last_diff), 32'h10000);
        checkOutput("vec3_skip", 32'(last_skip), 32'd4);

        applyStimulus(16'hFFFF, 16'h0000, 0);
        checkOutput("vec4_diff", 32'(last_diff), 32'h1FFFF);
        checkOutput("vec4_skip", 32'(last_skip), 32'd0);

        applyStimulus(16'h00F0, 16'h0F00, 10);

        a        = 16'h5555;
        b        = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_diff", 32'(diff_out), 32'd0);
        checkOutput("midreset_skip", 32'(skip_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h8000, 16'h7FFF, 0);
        checkOutput("vec5_diff", 32'(last_diff), 32'h10001);
        checkOutput("vec5_borrow", 32'(last_borrow), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            for (int k = 0; k < NBLK; k++) begin
                if ($urandom_range(0, 2) == 0) rb[k*BLOCK +: BLOCK] = ra[k*BLOCK +: BLOCK];
            end
            applyStimulus(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
